sdr_src_arbiter: RTL and testbench
==================================

SDR_SRC_ARBITER -- requirements
Module: sdr_src_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 2, number of AXIS requesters; legal range 2..4.
REQ-002 Parameter AXIS_BYTES, default 8, TDATA width in bytes (64b bus).
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 arb_enable  in  1  permits new grants; an in-flight frame always completes.
REQ-006 arb_mode  in  1  0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-007 src_mask  in  NUM_SRC  bit i = 1 makes source i eligible.
REQ-008 s_axis_tdata  in  NUM_SRC*AXIS_BYTES*8  packed; source i occupies slice i.
REQ-009 s_axis_tkeep  in  NUM_SRC*AXIS_BYTES  packed per source.
REQ-010 s_axis_tvalid / s_axis_tlast  in  NUM_SRC each  per-source valid / last.
REQ-011 s_axis_tready  out  NUM_SRC  per-source ready.
REQ-012 m_axis_tdata / tkeep / tvalid / tlast  out  AXIS_BYTES*8 / AXIS_BYTES / 1 / 1  merged TX stream.
REQ-013 m_axis_tready  in  1  downstream ready.
REQ-014 grant_id  out  2  index of the current or most recent grantee.
REQ-015 grant_active  out  1  high while in XFER.
REQ-016 frame_cnt  out  NUM_SRC*32  per-source completed-frame counters (ARB_STATS_EN only).

Function
REQ-017 FSM states: IDLE, XFER.
REQ-018 IDLE: if arb_enable and any (s_axis_tvalid & src_mask) bit is set, latch the winner into grant_id and enter XFER on the next edge; otherwise stay in IDLE.
REQ-019 Round-robin: search starts at index (last_grant+1) mod NUM_SRC and wraps; the first requesting eligible index wins.
REQ-020 Fixed priority: lowest requesting eligible index wins; the pointer still updates.
REQ-021 In XFER, s_axis_tready[grant_id] = can_load, where can_load = !out_valid or m_axis_tready; all other ready bits are 0.
REQ-022 In IDLE, all s_axis_tready bits are 0; arbitration costs exactly one idle cycle per frame.
REQ-023 Output stage is a one-deep register slice; a source beat is accepted on tvalid & tready and appears on m_axis one cycle later.
REQ-024 Slice valid clears when m_axis_tready & m_axis_tvalid and no new load occurs in the same cycle.
REQ-025 Accepting a source beat with tlast = 1 in XFER returns the FSM to IDLE on the next edge and sets last_grant = grant_id.
REQ-026 Deasserting arb_enable, or changing src_mask or arb_mode, mid-frame has no effect until the frame ends.
REQ-027 A masked source with tvalid high never receives tready.
REQ-028 m_axis output stalls hold tdata, tkeep and tlast stable while m_axis_tvalid & !m_axis_tready.
REQ-029 grant_id holds its value through IDLE until the next grant.

Reset
REQ-030 On rst_n low, asynchronously: FSM = IDLE, last_grant = NUM_SRC-1 (so source 0 wins first), grant_id = 0.
REQ-031 On rst_n low: m_axis_tvalid/tdata/tkeep/tlast = 0, s_axis_tready = 0, grant_active = 0.
REQ-032 On rst_n low: frame_cnt = 0.
REQ-033 Reset mid-frame discards the slice contents; no beat is emitted after reset release until a new grant occurs.

Configuration
REQ-034 Macro SDR_ARB_STATS_EN, when defined, instantiates NUM_SRC 32-bit counters; counter i increments on each m_axis tlast handshake sourced from i and wraps 0xFFFFFFFF -> 0.
REQ-035 When SDR_ARB_STATS_EN is undefined, frame_cnt is tied to 0 and no counter flops exist.

Verification
REQ-036 Reset release; src0 and src1 each continuously offer 3-beat frames; mode 0, mask 2'b11, m_tready = 1 -> output frames alternate src0, src1, src0, src1; one bubble per frame boundary.
REQ-037 Mode 1, both sources request continuously -> only src0 frames appear; src1 tready stays 0.
REQ-038 Mid-frame of a 5-beat src1 frame: drop arb_enable at beat 2 and set mask = 2'b01 -> all 5 beats are delivered, then the FSM goes IDLE with no new grant.
REQ-039 Toggle m_tready on a 1-0-1-0 pattern during a 4-beat frame with data 0x1..0x4 -> output is 0x1..0x4 in order, no loss or duplication, data stable during stalls.
REQ-040 rst_n pulsed low at beat 2 of a src0 frame -> outputs zero immediately; after release the first grant goes to src0.
REQ-041 With SDR_ARB_STATS_EN: frame_cnt[0] preset to 0xFFFFFFFF via force, one src0 frame sent -> frame_cnt[0] = 0 and frame_cnt[1] is unchanged.

Source files
------------

// File: rtl/sdr_src_arbiter.sv
// sdr_src_arbiter: merges NUM_SRC AXI-Stream sources into one frame-atomic TX stream.
// Optional macro SDR_ARB_STATS_EN adds per-source completed-frame counters on frame_cnt.
`timescale 1ns/1ps

module sdr_src_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int AXIS_BYTES = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            arb_enable,
  input  logic                            arb_mode,
  input  logic [NUM_SRC-1:0]              src_mask,
  input  logic [NUM_SRC*AXIS_BYTES*8-1:0] s_axis_tdata,
  input  logic [NUM_SRC*AXIS_BYTES-1:0]   s_axis_tkeep,
  input  logic [NUM_SRC-1:0]              s_axis_tvalid,
  input  logic [NUM_SRC-1:0]              s_axis_tlast,
  output logic [NUM_SRC-1:0]              s_axis_tready,
  output logic [AXIS_BYTES*8-1:0]         m_axis_tdata,
  output logic [AXIS_BYTES-1:0]           m_axis_tkeep,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,
  output logic [1:0]                      grant_id,
  output logic                            grant_active,
  output logic [NUM_SRC*32-1:0]           frame_cnt
);

  localparam int DW = AXIS_BYTES * 8;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t                state, state_nxt;
  logic [1:0]            last_grant, last_grant_nxt, grant_nxt;
  logic [NUM_SRC-1:0]    req;
  logic [DW-1:0]         sel_data;
  logic [AXIS_BYTES-1:0] sel_keep;
  logic                  sel_valid, sel_last;
  logic                  can_load, load;

  logic                  vld_p1;
  logic [DW-1:0]         data_p1;
  logic [AXIS_BYTES-1:0] keep_p1;
  logic                  last_p1;

  // Round-robin: winner is the requester at the smallest rotated distance past last.
  function automatic logic [1:0] pick_rr(input logic [NUM_SRC-1:0] r, input logic [1:0] last);
    int         best_d;
    int         d;
    logic [1:0] win;
    best_d = NUM_SRC;
    win    = 2'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      d = (i + 2 * NUM_SRC - int'(last) - 1) % NUM_SRC;
      if (r[i] && d < best_d) begin
        best_d = d;
        win    = 2'(i);
      end
    end
    return win;
  endfunction

  function automatic logic [1:0] pick_fixed(input logic [NUM_SRC-1:0] r);
    logic [1:0] win;
    win = 2'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (r[i]) win = 2'(i);
    end
    return win;
  endfunction

  assign req          = s_axis_tvalid & src_mask;
  assign can_load     = !vld_p1 || m_axis_tready;
  assign load         = (state == XFER) && sel_valid && can_load;
  assign grant_active = (state == XFER);

  always_comb begin
    sel_data  = '0;
    sel_keep  = '0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_id == 2'(i)) begin
        sel_data  = s_axis_tdata[i*DW +: DW];
        sel_keep  = s_axis_tkeep[i*AXIS_BYTES +: AXIS_BYTES];
        sel_valid = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
      end
    end
  end

  // Mode, mask and enable are only consulted in IDLE, so a granted frame always finishes.
  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant_id;
    last_grant_nxt = last_grant;
    s_axis_tready  = '0;
    case (state)
      IDLE: begin
        if (arb_enable && (|req)) begin
          state_nxt = XFER;
          grant_nxt = arb_mode ? pick_fixed(req) : pick_rr(req, last_grant);
        end
      end
      XFER: begin
        for (int i = 0; i < NUM_SRC; i++) begin
          if (grant_id == 2'(i)) s_axis_tready[i] = can_load;
        end
        if (load && sel_last) begin
          state_nxt      = IDLE;
          last_grant_nxt = grant_id;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 2'(NUM_SRC - 1);
      grant_id   <= 2'd0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant_id   <= grant_nxt;
    end
  end

  // Stage p1: one-deep output register slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      keep_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= sel_data;
      keep_p1 <= sel_keep;
      last_p1 <= sel_last;
    end else if (m_axis_tready) begin
      vld_p1  <= 1'b0;
    end
  end

  assign m_axis_tvalid = vld_p1;
  assign m_axis_tdata  = data_p1;
  assign m_axis_tkeep  = keep_p1;
  assign m_axis_tlast  = last_p1;

`ifdef SDR_ARB_STATS_EN
  logic [1:0]           src_p1;
  logic [NUM_SRC*32-1:0] cnt_q;

  // Source tag rides alongside the slice so the counter credits the right source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_p1 <= 2'd0;
    end else if (load) begin
      src_p1 <= grant_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (vld_p1 && m_axis_tready && last_p1) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_p1 == 2'(i)) cnt_q[i*32 +: 32] <= cnt_q[i*32 +: 32] + 32'd1;
      end
    end
  end

  assign frame_cnt = cnt_q;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: tb/tb_sdr_src_arbiter.sv
// Self-checking bench for sdr_src_arbiter: directed scenarios plus randomized frames
// checked against a frame-level arbitration model.
`timescale 1ns/1ps

module tb_sdr_src_arbiter;
  localparam int NS = 2;
  localparam int NB = 8;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [1:0]  src;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          arb_enable, arb_mode;
  logic [1:0]    src_mask;
  logic [127:0]  s_axis_tdata;
  logic [15:0]   s_axis_tkeep;
  logic [1:0]    s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [63:0]   m_axis_tdata;
  logic [7:0]    m_axis_tkeep;
  logic          m_axis_tvalid, m_axis_tlast, m_axis_tready;
  logic [1:0]    grant_id;
  logic          grant_active;
  logic [63:0]   frame_cnt;

  sdr_src_arbiter #(.NUM_SRC(NS), .AXIS_BYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .arb_enable(arb_enable), .arb_mode(arb_mode),
    .src_mask(src_mask), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready), .grant_id(grant_id),
    .grant_active(grant_active), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  beat_t       src_mem [NS][256];
  int          src_len [NS];
  int          src_rd  [NS];
  int          src_frm [NS];
  beat_t       exp_q[$];
  logic [1:0]  model_last;
  logic [31:0] frames_done [NS];
  int          rdy_mode;
  bit          rdy_tog, gap_en, mask_chk, prio_chk, bubble_chk;
  int          cycle, last_hs_cyc;
  bit          have_prev, prev_last, prev_stall;
  logic [63:0] prev_data;
  logic [7:0]  prev_keep;
  logic        prev_tlast;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic add_frame(input int s, input int len, input bit rnd);
    beat_t bt;
    for (int b = 0; b < len; b++) begin
      bt.data = rnd ? {8'(s), 8'(src_frm[s]), 8'(b), 8'($urandom), $urandom} : 64'(b + 1);
      bt.keep = rnd ? 8'($urandom) : 8'hFF;
      bt.last = (b == len - 1);
      bt.src  = 2'(s);
      src_mem[s][src_len[s]] = bt;
      src_len[s]++;
    end
    src_frm[s]++;
  endtask

  task automatic clear_src();
    for (int s = 0; s < NS; s++) begin
      src_len[s] = 0;
      src_rd[s]  = 0;
    end
  endtask

  // Frame-level model: each arbitration picks among sources that still hold frames.
  task automatic build_exp(input bit mode, input logic [1:0] mask);
    int    rd [NS];
    int    w, idx, guard;
    beat_t b;
    for (int s = 0; s < NS; s++) rd[s] = src_rd[s];
    for (int f = 0; f < 64; f++) begin
      w = -1;
      for (int k = 0; k < NS; k++) begin
        idx = mode ? k : (int'(model_last) + 1 + k) % NS;
        if (w < 0 && mask[idx] && rd[idx] < src_len[idx]) w = idx;
      end
      if (w < 0) break;
      guard = 0;
      do begin
        b = src_mem[w][rd[w]];
        rd[w]++;
        guard++;
        exp_q.push_back(b);
      end while (!b.last && rd[w] < src_len[w] && guard < 256);
      model_last = 2'(w);
    end
  endtask

  task automatic step();
    beat_t b;
    bit    v;
    bit    hs [NS];
    beat_t e;
    @(negedge clk);
    for (int s = 0; s < NS; s++) begin
      if (src_rd[s] < src_len[s]) begin
        b = src_mem[s][src_rd[s]];
        v = 1'b1;
        if (gap_en && src_rd[s] > 0 && !src_mem[s][src_rd[s]-1].last && $urandom_range(3) == 0)
          v = 1'b0;
      end else begin
        b = '0;
        v = 1'b0;
      end
      s_axis_tvalid[s]         = v;
      s_axis_tdata[s*64 +: 64] = b.data;
      s_axis_tkeep[s*8 +: 8]   = b.keep;
      s_axis_tlast[s]          = b.last;
    end
    case (rdy_mode)
      1:       m_axis_tready = 1'($urandom_range(1));
      2:       begin m_axis_tready = rdy_tog; rdy_tog = !rdy_tog; end
      default: m_axis_tready = 1'b1;
    endcase
    #1;
    if (mask_chk) chk("masked_ready", s_axis_tready & ~src_mask, 0);
    if (prio_chk && src_rd[0] < src_len[0]) chk("prio_src1_ready", s_axis_tready[1], 0);
    if (prev_stall) begin
      chk("stall_valid", m_axis_tvalid, 1);
      chk("stall_data", m_axis_tdata, prev_data);
      chk("stall_keep", m_axis_tkeep, prev_keep);
      chk("stall_last", m_axis_tlast, prev_tlast);
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", m_axis_tvalid & m_axis_tready, 0);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", m_axis_tdata, e.data);
        chk("out_keep", m_axis_tkeep, e.keep);
        chk("out_last", m_axis_tlast, e.last);
        if (e.last) frames_done[e.src] = frames_done[e.src] + 32'd1;
        if (bubble_chk && have_prev) chk("beat_spacing", cycle - last_hs_cyc, prev_last ? 2 : 1);
        have_prev   = 1'b1;
        prev_last   = e.last;
        last_hs_cyc = cycle;
      end
    end
    prev_stall = m_axis_tvalid && !m_axis_tready;
    prev_data  = m_axis_tdata;
    prev_keep  = m_axis_tkeep;
    prev_tlast = m_axis_tlast;
    for (int s = 0; s < NS; s++) hs[s] = s_axis_tvalid[s] && s_axis_tready[s];
    @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++) if (hs[s]) src_rd[s]++;
    cycle++;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    repeat (4) step();
    exp_q.delete();
    have_prev = 1'b0;
  endtask

  task automatic chk_cnt();
`ifdef SDR_ARB_STATS_EN
    chk("frame_cnt0", frame_cnt[31:0], frames_done[0]);
    chk("frame_cnt1", frame_cnt[63:32], frames_done[1]);
`else
    chk("frame_cnt_tied", frame_cnt, 0);
`endif
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_valid"}, m_axis_tvalid, 0);
    chk({tag, "_m_data"}, m_axis_tdata, 0);
    chk({tag, "_m_keep"}, m_axis_tkeep, 0);
    chk({tag, "_m_last"}, m_axis_tlast, 0);
    chk({tag, "_s_ready"}, s_axis_tready, 0);
    chk({tag, "_grant_active"}, grant_active, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_frame_cnt"}, frame_cnt, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0; arb_enable = 1'b0; arb_mode = 1'b0; src_mask = 2'b00;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
    m_axis_tready = 1'b1;
    rdy_mode = 0; rdy_tog = 1'b1; gap_en = 0; mask_chk = 0; prio_chk = 0; bubble_chk = 0;
    cycle = 0; last_hs_cyc = 0; have_prev = 0; prev_last = 0; prev_stall = 0;
    prev_data = '0; prev_keep = '0; prev_tlast = 1'b0;
    model_last = 2'(NS - 1);
    for (int s = 0; s < NS; s++) begin
      src_len[s] = 0; src_rd[s] = 0; src_frm[s] = 0; frames_done[s] = 32'd0;
    end

    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Round-robin alternation with one bubble per frame boundary.
    arb_enable = 1'b1; arb_mode = 1'b0; src_mask = 2'b11;
    mask_chk = 1; bubble_chk = 1;
    for (int f = 0; f < 3; f++) begin
      add_frame(0, 3, 1);
      add_frame(1, 3, 1);
    end
    build_exp(1'b0, 2'b11);
    drain(200);
    bubble_chk = 0;
    chk("rr_idle_grant_active", grant_active, 0);
    chk("rr_grant_id_holds", grant_id, 1);
    chk_cnt();
    clear_src();

    // Fixed priority: src0 starves src1 while it has frames.
    arb_mode = 1'b1; prio_chk = 1;
    add_frame(0, 2, 1); add_frame(0, 4, 1); add_frame(0, 3, 1);
    add_frame(1, 2, 1); add_frame(1, 3, 1);
    build_exp(1'b1, 2'b11);
    drain(200);
    prio_chk = 0;
    clear_src();

    // Enable dropped and mask narrowed mid-frame: frame completes, no new grant.
    arb_mode = 1'b0; mask_chk = 0;
    add_frame(1, 5, 1);
    build_exp(1'b0, 2'b11);
    n = 0;
    while (src_rd[1] < 2 && n < 50) begin step(); n++; end
    chk("midframe_reach_beat2", src_rd[1] >= 2, 1);
    arb_enable = 1'b0; src_mask = 2'b01;
    add_frame(0, 3, 1);
    drain(100);
    chk("midframe_idle", grant_active, 0);
    chk("midframe_grant_id", grant_id, 1);
    chk("midframe_no_new_grant", src_rd[0], 0);
    arb_enable = 1'b1; src_mask = 2'b11;
    build_exp(1'b0, 2'b11);
    drain(100);
    mask_chk = 1;
    clear_src();

    // Output backpressure on a 1-0-1-0 pattern.
    rdy_mode = 2; rdy_tog = 1'b1;
    add_frame(0, 4, 0);
    build_exp(1'b0, 2'b11);
    drain(100);
    rdy_mode = 0;
    clear_src();

    // Asynchronous reset in the middle of a src0 frame.
    add_frame(0, 6, 1);
    build_exp(1'b0, 2'b11);
    n = 0;
    while (src_rd[0] < 2 && n < 50) begin step(); n++; end
    chk("rst_reach_beat2", src_rd[0] >= 2, 1);
    #2;
    rst_n = 1'b0;
    s_axis_tvalid = '0;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    clear_src();
    model_last = 2'(NS - 1);
    for (int s = 0; s < NS; s++) frames_done[s] = 32'd0;
    prev_stall = 0; have_prev = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) step();
    add_frame(1, 2, 1);
    add_frame(0, 3, 1);
    build_exp(1'b0, 2'b11);
    drain(100);
    chk("postrst_last_grant_src", grant_id, 1);
    chk_cnt();
    clear_src();

    // Randomized frames, modes, masks, gaps and backpressure.
    rdy_mode = 1; gap_en = 1;
    for (int p = 0; p < 8; p++) begin
      logic [1:0] mk;
      logic       md;
      md = 1'($urandom_range(1));
      mk = 2'($urandom_range(1, 3));
      arb_mode = md; src_mask = mk;
      for (int s = 0; s < NS; s++) begin
        int nf;
        nf = $urandom_range(1, 3);
        for (int f = 0; f < nf; f++) add_frame(s, $urandom_range(1, 6), 1);
      end
      build_exp(md, mk);
      drain(2000);
      chk_cnt();
      clear_src();
    end
    rdy_mode = 0; gap_en = 0; arb_mode = 1'b0; src_mask = 2'b11;

`ifdef SDR_ARB_STATS_EN
    // Counter wrap: preset src0 counter to all ones.
    force dut.cnt_q = {frames_done[1], 32'hFFFF_FFFF};
    frames_done[0] = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.cnt_q;
    @(posedge clk);
    #1;
    add_frame(0, 2, 1);
    build_exp(1'b0, 2'b11);
    drain(100);
    chk_cnt();
    chk("cnt_wrap_zero", frame_cnt[31:0], 0);
    clear_src();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
